// File: rtl/cpaep_stream_pkg.sv
// Shared types and sizing helpers for the operand stream readers.
package cpaep_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fsm_state_t;

    // Number of IO elements packed into one external memory word.
    function automatic int unsigned elems_per_word(input int unsigned mem_w, input int unsigned io_w);
        return mem_w / io_w;
    endfunction

    // Word address width for a memory of the given depth.
    function automatic int unsigned addr_width(input int unsigned height);
        return (height > 1) ? unsigned'($clog2(height)) : 1;
    endfunction

endpackage

// File: rtl/stream_word_fifo.sv
// Two-entry register FIFO holding fetched memory words; slot0 is always the head.
module stream_word_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;

    // Next-state for storage and occupancy; pop shifts slot1 into the head.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = push_data;
                end else begin
                    slot1_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_data;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_q == count_d ? count_q : count_d;
        end
    end

    assign head_data = slot0_q;
    assign count     = count_q;

endmodule

// File: rtl/ext_mem_stream_reader.sv
// Reads a contiguous block of external memory words and streams their
// IO-width slices, low slice first, on a valid/ready interface.
module ext_mem_stream_reader
    import cpaep_stream_pkg::*;
#(
    parameter int unsigned IO_DATA_WIDTH  = 16,
    parameter int unsigned EXT_MEM_WIDTH  = 32,
    parameter int unsigned EXT_MEM_HEIGHT = 1 << 20,
    localparam int unsigned ADDR_W = addr_width(EXT_MEM_HEIGHT)
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          nb_elems,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        ext_mem_read_addr,
    output logic                     ext_mem_read_en,
    input  logic [EXT_MEM_WIDTH-1:0] ext_mem_qout,
    output logic [IO_DATA_WIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned ELEMS_PER_WORD = elems_per_word(EXT_MEM_WIDTH, IO_DATA_WIDTH);
    localparam int unsigned SLICE_W        = (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;
    localparam int unsigned CNT_W          = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(EXT_MEM_HEIGHT - 1);

    function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    fsm_state_t          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                read_en_q, read_en_d;
    logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    nb_words_q, nb_words_d;
    logic [CNT_W-1:0]    nb_elems_q, nb_elems_d;
    logic [CNT_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic [SLICE_W-1:0]  slice_q, slice_d;
    logic                inflight_q, inflight_d;

    logic                     fifo_push, fifo_pop, fifo_has_word;
    logic [EXT_MEM_WIDTH-1:0] fifo_head, head_word;
    logic [1:0]               fifo_count, fifo_count_next;
    logic [IO_DATA_WIDTH-1:0] head_slice;
    logic                     stream_valid, handshake, last_elem, last_slice, word_done;
    logic [CNT_W-1:0]         start_words;

    stream_word_fifo #(
        .WIDTH(EXT_MEM_WIDTH)
    ) u_word_fifo (
        .clk       (clk),
        .rst_n     (arst_n_in),
        .push      (fifo_push),
        .push_data (ext_mem_qout),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Unpacker: the word returning from memory is presented directly while the
    // FIFO is empty, and is only pushed if it still has slices left afterwards.
    always_comb begin
        fifo_has_word = (fifo_count != 2'd0);
        head_word     = fifo_has_word ? fifo_head : ext_mem_qout;
        stream_valid  = fifo_has_word || inflight_q;
        head_slice    = '0;
        for (int unsigned i = 0; i < ELEMS_PER_WORD; i++) begin
            if (slice_q == SLICE_W'(i)) begin
                head_slice = head_word[i*IO_DATA_WIDTH +: IO_DATA_WIDTH];
            end
        end
        handshake       = stream_valid && out_ready;
        last_elem       = (elem_cnt_q == nb_elems_q - CNT_W'(1));
        last_slice      = (slice_q == SLICE_W'(ELEMS_PER_WORD - 1)) || last_elem;
        word_done       = handshake && last_slice;
        fifo_pop        = word_done && fifo_has_word;
        fifo_push       = inflight_q && !(word_done && !fifo_has_word);
        fifo_count_next = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
        start_words     = CNT_W'(({1'b0, nb_elems} + (CNT_W + 1)'(ELEMS_PER_WORD - 1))
                                 / (CNT_W + 1)'(ELEMS_PER_WORD));
    end

    // Transfer control: next state, read issue under the two-word credit, counters.
    always_comb begin
        state_d     = state_q;
        read_en_d   = 1'b0;
        read_addr_d = read_addr_q;
        next_addr_d = next_addr_q;
        word_cnt_d  = word_cnt_q;
        nb_words_d  = nb_words_q;
        nb_elems_d  = nb_elems_q;
        elem_cnt_d  = elem_cnt_q;
        slice_d     = slice_q;
        inflight_d  = read_en_q;

        if (handshake) begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
            slice_d    = last_slice ? '0 : slice_q + SLICE_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nb_elems_d = nb_elems;
                    nb_words_d = start_words;
                    elem_cnt_d = '0;
                    slice_d    = '0;
                    word_cnt_d = '0;
                    if (nb_elems == '0) begin
                        state_d = DONE;
                    end else begin
                        // First read goes out the cycle after start, so the
                        // counter leaves IDLE already accounting for it.
                        read_en_d   = 1'b1;
                        read_addr_d = base_addr;
                        next_addr_d = next_word_addr(base_addr);
                        word_cnt_d  = CNT_W'(1);
                        state_d     = (start_words == CNT_W'(1)) ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                // Words held next cycle plus the read now in flight must leave room.
                if ((3'(fifo_count_next) + 3'(read_en_q)) < 3'd2) begin
                    read_en_d   = 1'b1;
                    read_addr_d = next_addr_q;
                    next_addr_d = next_word_addr(next_addr_q);
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q + CNT_W'(1) == nb_words_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (handshake && last_elem) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_d = (state_d == FETCH) || (state_d == DRAIN);
    assign done_d = (state_d == DONE);

    // All control state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
            next_addr_q <= '0;
            word_cnt_q  <= '0;
            nb_words_q  <= '0;
            nb_elems_q  <= '0;
            elem_cnt_q  <= '0;
            slice_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_en_q   <= read_en_d;
            read_addr_q <= read_addr_d;
            next_addr_q <= next_addr_d;
            word_cnt_q  <= word_cnt_d;
            nb_words_q  <= nb_words_d;
            nb_elems_q  <= nb_elems_d;
            elem_cnt_q  <= elem_cnt_d;
            slice_q     <= slice_d;
            inflight_q  <= inflight_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign ext_mem_read_en   = read_en_q;
    assign ext_mem_read_addr = read_addr_q;
    assign out_valid         = stream_valid;
    assign out_data          = stream_valid ? head_slice : '0;

endmodule

// File: tb/tb_ext_mem_stream_reader.sv
// Self-checking bench for ext_mem_stream_reader against a behavioural model
// that derives element order and read addresses from the block's rules.
module tb_ext_mem_stream_reader;

    localparam int unsigned IO_W  = 16;
    localparam int unsigned MEM_W = 32;
    localparam int unsigned H     = 1 << 20;
    localparam int unsigned AW    = 20;
    localparam int unsigned EPW   = MEM_W / IO_W;

    logic              clk = 1'b0;
    logic              arst_n_in;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       nb_elems;
    logic              busy;
    logic              done;
    logic [AW-1:0]     ext_mem_read_addr;
    logic              ext_mem_read_en;
    logic [MEM_W-1:0]  ext_mem_qout;
    logic [IO_W-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    logic [MEM_W-1:0] mem [int unsigned];

    ext_mem_stream_reader #(
        .IO_DATA_WIDTH (IO_W),
        .EXT_MEM_WIDTH (MEM_W),
        .EXT_MEM_HEIGHT(H)
    ) dut (
        .clk              (clk),
        .arst_n_in        (arst_n_in),
        .start            (start),
        .base_addr        (base_addr),
        .nb_elems         (nb_elems),
        .busy             (busy),
        .done             (done),
        .ext_mem_read_addr(ext_mem_read_addr),
        .ext_mem_read_en  (ext_mem_read_en),
        .ext_mem_qout     (ext_mem_qout),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [MEM_W-1:0] mem_rd(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    // Synchronous-read memory; junk on qout whenever no read was issued.
    always @(posedge clk) begin
        ext_mem_qout <= ext_mem_read_en ? mem_rd(32'(ext_mem_read_addr)) : MEM_W'($urandom);
    end

    // One transfer, checked cycle by cycle against the expected element list.
    task automatic run_transfer(input int unsigned base, input int unsigned nb,
                                input bit rand_ready, input bit inject_start, input string name);
        logic [IO_W-1:0] exp_q[$];
        int unsigned     addr_q[$];
        int unsigned     nwords, reads, hs, last_hs_cycle, done_cnt, first_valid, c;
        bit              stalled, injected, exp_busy, exp_done, s_valid, s_done, s_busy, s_ren;
        logic [IO_W-1:0] held, s_data;
        logic [AW-1:0]   s_addr;
        logic [MEM_W-1:0] w;
        nwords = (nb + EPW - 1) / EPW;
        reads = 0; hs = 0; last_hs_cycle = 0; done_cnt = 0; first_valid = 0;
        stalled = 0; injected = 0; held = '0;
        for (int unsigned i = 0; i < nwords; i++) addr_q.push_back((base + i) % H);
        for (int unsigned i = 0; i < nb; i++) begin
            w = mem_rd((base + i / EPW) % H);
            exp_q.push_back(w[(i % EPW) * IO_W +: IO_W]);
        end

        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); nb_elems = (AW + 1)'(nb); out_ready = 1'b1;
        c = 0;
        while (c < 300) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
            s_valid = out_valid; s_data = out_data; s_done = done; s_busy = busy;
            s_ren = ext_mem_read_en; s_addr = ext_mem_read_addr;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            exp_busy = (nb != 0) && (hs < nb);
            exp_done = (nb == 0) ? (c == 1) : (hs == nb && c == last_hs_cycle + 1);
            checks++;
            if (s_busy !== exp_busy) begin
                errors++; $display("FAIL %s busy@%0d: got %0b, required %0b", name, c, s_busy, exp_busy);
            end
            checks++;
            if (s_done !== exp_done) begin
                errors++; $display("FAIL %s done@%0d: got %0b, required %0b", name, c, s_done, exp_done);
            end
            if (s_done === 1'b1) done_cnt++;

            if (s_ren === 1'b1) begin
                checks++;
                if (reads >= nwords) begin
                    errors++; $display("FAIL %s extra_read@%0d: addr %0d, required no read", name, c, s_addr);
                end else if (32'(s_addr) !== addr_q[reads]) begin
                    errors++; $display("FAIL %s read_addr#%0d: got %0d, required %0d", name, reads, s_addr, addr_q[reads]);
                end
                reads++;
            end
            checks++;
            if (reads > hs / EPW + 2) begin
                errors++; $display("FAIL %s buffered@%0d: got %0d words outstanding, required <= 2", name, c, reads - hs / EPW);
            end

            if (stalled) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== held) begin
                    errors++; $display("FAIL %s stall_hold@%0d: got v=%0b d=%0h, required v=1 d=%0h", name, c, s_valid, s_data, held);
                end
            end
            stalled = 0;
            if (s_valid === 1'b1) begin
                if (first_valid == 0) first_valid = c;
                checks++;
                if (hs >= nb) begin
                    errors++; $display("FAIL %s extra_valid@%0d: got data %0h, required out_valid=0", name, c, s_data);
                end else if (s_data !== exp_q[hs]) begin
                    errors++; $display("FAIL %s data#%0d: got %0h, required %0h", name, hs, s_data, exp_q[hs]);
                end
                if (out_ready) begin
                    hs++; last_hs_cycle = c;
                end else begin
                    stalled = 1; held = s_data;
                end
            end

            if (inject_start && !injected && reads == nwords && hs < nb) begin
                start = 1'b1; base_addr = AW'((base + 37) % H); nb_elems = (AW + 1)'(5); injected = 1;
            end
            if (hs == nb && c >= last_hs_cycle + 4) break;
        end

        checks++;
        if (hs != nb || (nb != 0 && c >= 300)) begin
            errors++; $display("FAIL %s completion: got %0d elements in %0d cycles, required %0d", name, hs, c, nb);
        end
        checks++;
        if (reads != nwords) begin
            errors++; $display("FAIL %s read_count: got %0d, required %0d", name, reads, nwords);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        if (nb != 0) begin
            checks++;
            if (first_valid != 2) begin
                errors++; $display("FAIL %s latency: got first valid at %0d, required 2", name, first_valid);
            end
            if (!rand_ready) begin
                checks++;
                if (last_hs_cycle != nb + 1) begin
                    errors++; $display("FAIL %s throughput: got last element at %0d, required %0d", name, last_hs_cycle, nb + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        arst_n_in = 1'b0; start = 1'b0; base_addr = '0; nb_elems = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, ext_mem_read_en, out_valid} !== 4'b0 || ext_mem_read_addr !== '0 || out_data !== '0) begin
            errors++; $display("FAIL reset_state: got busy=%0b done=%0b ren=%0b addr=%0h v=%0b d=%0h, required all 0",
                               busy, done, ext_mem_read_en, ext_mem_read_addr, out_valid, out_data);
        end
        arst_n_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, ext_mem_read_en, out_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_idle: got busy=%0b done=%0b ren=%0b v=%0b, required all 0", busy, done, ext_mem_read_en, out_valid);
        end
    endtask

    task automatic test_basic();
        run_transfer(100, 4, 0, 0, "basic");
    endtask

    task automatic test_odd_length();
        run_transfer(100, 3, 0, 0, "odd_length");
    endtask

    task automatic test_backpressure();
        run_transfer(100, 8, 1, 0, "backpressure");
    endtask

    task automatic test_random_transfers();
        int unsigned b, n;
        for (int k = 0; k < 4; k++) begin
            b = $urandom_range(0, H - 1);
            n = $urandom_range(1, 12);
            for (int unsigned i = 0; i < (n + EPW - 1) / EPW; i++) mem[(b + i) % H] = $urandom;
            run_transfer(b, n, 1'(k % 2), 0, "random");
        end
    endtask

    task automatic test_wrap();
        mem[H - 1] = $urandom;
        mem[0]     = $urandom;
        run_transfer(H - 1, 4, 0, 0, "wrap");
    endtask

    task automatic test_zero_length();
        run_transfer(100, 0, 0, 0, "zero_length");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(100); nb_elems = (AW + 1)'(8); out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ext_mem_read_en !== 1'b1) begin
            errors++; $display("FAIL reset_mid_read: got ren=%0b, required 1", ext_mem_read_en);
        end
        arst_n_in = 1'b0;
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        checks++;
        if ({busy, done, ext_mem_read_en, out_valid} !== 4'b0 || ext_mem_read_addr !== '0 || out_data !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got busy=%0b done=%0b ren=%0b addr=%0h v=%0b d=%0h, required all 0",
                               busy, done, ext_mem_read_en, ext_mem_read_addr, out_valid, out_data);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, ext_mem_read_en, out_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_mid_qout_ignored: got busy=%0b done=%0b ren=%0b v=%0b, required all 0",
                               busy, done, ext_mem_read_en, out_valid);
        end
        run_transfer(100, 2, 0, 0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        run_transfer(100, 8, 1, 1, "start_while_busy");
    endtask

    initial begin
        mem[100] = 32'h0002_0001;
        mem[101] = 32'h0004_0003;
        mem[102] = $urandom;
        mem[103] = $urandom;
        test_reset();
        test_basic();
        test_odd_length();
        test_backpressure();
        test_random_transfers();
        test_wrap();
        test_zero_length();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
